// File: rtl/program_mem_responder.sv
// Program store for the T/E fetch stream: 1-cycle registered reads, byte loader with valid/ready (ready only while loading).
// Optional load checksum byte enabled by PROGRAM_MEM_CHECKSUM_EN; without it err is constant 0.
module program_mem_responder #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cycle,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_cycle,
  input  logic              ld_start,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [7:0]        cfg_state_offs,
  output logic [7:0]        cfg_trans_offs,
  output logic              run,
  output logic              err
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, HDR_S, HDR_T, LEN, LOAD, RUN, ERR
`ifdef PROGRAM_MEM_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [MEM_DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        remaining;
  logic [8:0]        len_full;
  logic [8:0]        len_clamped;
  logic              beat;
  logic              rd_in_range;
  logic [MEM_AW-1:0] rd_idx;
  logic [MEM_AW-1:0] wr_idx;

`ifdef PROGRAM_MEM_CHECKSUM_EN
  logic [7:0]        ck_sum;
  logic [7:0]        ck_total;
  assign ck_total = ck_sum + ld_data;
`endif

  // ld_start wins over a beat presented in the same cycle
  assign beat        = ld_valid & ld_ready & ~ld_start;
  assign len_full    = (ld_data == 8'd0) ? 9'd256 : {1'b0, ld_data};
  assign len_clamped = (32'(len_full) > 32'(MEM_DEPTH)) ? 9'(MEM_DEPTH) : len_full;
  assign rd_in_range = 32'(rd_addr) < 32'(MEM_DEPTH);
  assign rd_idx      = MEM_AW'(rd_addr);
  assign wr_idx      = MEM_AW'(ptr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    run       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: ;
      HDR_S: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = HDR_T;
      end
      HDR_T: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = LEN;
      end
      LEN: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && remaining == 9'd1) begin
`ifdef PROGRAM_MEM_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = RUN;
`endif
        end
      end
`ifdef PROGRAM_MEM_CHECKSUM_EN
      CHK: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = (ck_total == 8'd0) ? RUN : ERR;
      end
      ERR: err = 1'b1;
`endif
      RUN: run = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (ld_start) state_nxt = HDR_S;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      remaining      <= '0;
      cfg_state_offs <= 8'h00;
      cfg_trans_offs <= 8'h00;
      rd_data        <= 8'h00;
      rd_cycle       <= 1'b0;
`ifdef PROGRAM_MEM_CHECKSUM_EN
      ck_sum         <= 8'h00;
`endif
    end else begin
      rd_cycle <= cycle;
      rd_data  <= (state == RUN && rd_in_range) ? mem[rd_idx] : 8'h00;
      if (beat) begin
        case (state)
          HDR_S: cfg_state_offs <= ld_data;
          HDR_T: cfg_trans_offs <= ld_data;
          LEN: begin
            remaining <= len_clamped;
            ptr       <= '0;
`ifdef PROGRAM_MEM_CHECKSUM_EN
            ck_sum    <= ld_data;
`endif
          end
          LOAD: begin
            remaining <= remaining - 9'd1;
            // hold the pointer on the last byte so it stays inside the array
            if (remaining != 9'd1) ptr <= ptr + 1'b1;
`ifdef PROGRAM_MEM_CHECKSUM_EN
            ck_sum    <= ck_total;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Writes only happen in LOAD, so they never collide with RUN reads
  always_ff @(posedge clk) begin
    if (beat && state == LOAD) mem[wr_idx] <= ld_data;
  end

endmodule

// File: tb/tb_program_mem_responder.sv
// Randomized load/fetch bench for program_mem_responder against an array-based reference model.
module tb_program_mem_responder;

`ifdef PROGRAM_MEM_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cycle = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       ld_start = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_valid = 1'b0;
  logic [7:0] rd_data, rd_data4;
  logic       rd_cycle, rd_cycle4;
  logic       ld_ready, ld_ready4;
  logic [7:0] cfg_s, cfg_t, cfg_s4, cfg_t4;
  logic       run, run4, err, err4;

  always #5 clk = ~clk;

  program_mem_responder dut (
    .clk(clk), .reset(reset), .cycle(cycle), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_cycle(rd_cycle), .ld_start(ld_start),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .cfg_state_offs(cfg_s), .cfg_trans_offs(cfg_t), .run(run), .err(err)
  );

  program_mem_responder #(.MEM_DEPTH(4), .ADDR_W(8)) dut4 (
    .clk(clk), .reset(reset), .cycle(cycle), .rd_addr(rd_addr),
    .rd_data(rd_data4), .rd_cycle(rd_cycle4), .ld_start(ld_start),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready4),
    .cfg_state_offs(cfg_s4), .cfg_trans_offs(cfg_t4), .run(run4), .err(err4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_mem [256];
  logic [7:0] model4 [4];
  logic [7:0] payload [$];
  bit         m_run = 1'b0;
  bit         m_err = 1'b0;
  bit         m4_ok = 1'b1;
  logic [7:0] m_s = 8'h00;
  logic [7:0] m_t = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] b, input bit gap);
    int n = 0;
    ld_data  = b;
    ld_valid = 1'b1;
    while (!ld_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ld_ready_timeout", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    if (gap) tick();
  endtask

  // Sends header, length, payload (and checksum byte in that build), then updates the model.
  task automatic load_body(input logic [7:0] s, input logic [7:0] t, input logic [7:0] len_b,
                           input bit gap, input bit bad_ck);
    int         eff;
    logic [7:0] sum;
    eff = (len_b == 8'd0) ? 256 : int'(len_b);
    sum = len_b;
    send_beat(s, gap);
    send_beat(t, gap);
    send_beat(len_b, gap);
    for (int i = 0; i < eff; i++) begin
      send_beat(payload[i], gap);
      sum = sum + payload[i];
      model_mem[i] = payload[i];
      if (i < 4) model4[i] = payload[i];
    end
    if (CK_EN) send_beat(bad_ck ? 8'(8'd1 - sum) : 8'(8'd0 - sum), gap);
    m_s   = s;
    m_t   = t;
    m_run = !(CK_EN && bad_ck);
    m_err = CK_EN && bad_ck;
    m4_ok = !CK_EN || eff <= 4;
    check("cfg_state_offs", 32'(cfg_s), 32'(m_s));
    check("cfg_trans_offs", 32'(cfg_t), 32'(m_t));
    check("run_after_load", 32'(run), 32'(m_run));
    check("err_after_load", 32'(err), 32'(m_err));
    check("ld_ready_after_load", 32'(ld_ready), 32'd0);
    if (m4_ok) check("run4_after_load", 32'(run4), 32'(m_run));
  endtask

  task automatic do_load(input logic [7:0] s, input logic [7:0] t, input logic [7:0] len_b,
                         input bit gap, input bit bad_ck);
    pulse_start();
    load_body(s, t, len_b, gap, bad_ck);
  endtask

  task automatic read_chk(input logic [7:0] a, input bit c);
    logic [7:0] exp;
    rd_addr = a;
    cycle   = c;
    tick();
    exp = m_run ? model_mem[a] : 8'h00;
    check("rd_data", 32'(rd_data), 32'(exp));
    check("rd_cycle", 32'(rd_cycle), 32'(c));
    if (m4_ok) begin
      exp = (m_run && a < 8'd4) ? model4[a[1:0]] : 8'h00;
      check("rd_data_depth4", 32'(rd_data4), 32'(exp));
    end
  endtask

  task automatic fill_payload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_cycle", 32'(rd_cycle), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cfg_s", 32'(cfg_s), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("idle_ld_ready", 32'(ld_ready), 32'd0);
    read_chk(8'h05, 1'b1);

    // Reset asserted in the middle of a load, pointer at 5
    pulse_start();
    send_beat(8'h5A, 1'b0);
    send_beat(8'hA5, 1'b0);
    send_beat(8'd20, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(8'($urandom), 1'b0);
    ld_data  = 8'hEE;
    ld_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_run", 32'(run), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    check("midrst_cfg_s", 32'(cfg_s), 32'd0);
    check("midrst_cfg_t", 32'(cfg_t), 32'd0);
    ld_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("postrst_idle_ready", 32'(ld_ready), 32'd0);
    check("postrst_run", 32'(run), 32'd0);

    // Full 256-byte load (length byte 0) with gaps, then random fetches
    fill_payload(256);
    do_load(8'($urandom), 8'($urandom), 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) read_chk(8'($urandom), 1'($urandom));
    read_chk(8'h04, 1'b0);
    read_chk(8'h03, 1'b1);

    // Basic load
    payload.delete();
    payload.push_back(8'hA1);
    payload.push_back(8'hB2);
    payload.push_back(8'hC3);
    do_load(8'h10, 8'h20, 8'h03, 1'b0, 1'b0);
    read_chk(8'h02, 1'b1);
    check("basic_byte2", 32'(rd_data), 32'h0000_00C3);
    read_chk(8'h05, 1'b0);
    read_chk(8'h04, 1'b1);

    // Same stream with gaps
    do_load(8'h10, 8'h20, 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) read_chk(8'(i), 1'(i));

    // Reload that overwrites address 5
    fill_payload(6);
    do_load(8'($urandom), 8'($urandom), 8'd6, 1'b0, 1'b0);
    read_chk(8'h05, 1'b1);

    // ld_start together with a beat at pointer 1
    pulse_start();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'd4, 1'b0);
    send_beat(8'h99, 1'b0);
    model_mem[0] = 8'h99;
    model4[0]    = 8'h99;
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h77;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("restart_ld_ready", 32'(ld_ready), 32'd1);
    check("restart_run", 32'(run), 32'd0);
    payload.delete();
    payload.push_back(8'hE7);
    load_body(8'h55, 8'h66, 8'd1, 1'b0, 1'b0);
    read_chk(8'h00, 1'b0);
    read_chk(8'h01, 1'b1);

    // Random loads and fetches
    for (int k = 0; k < 3; k++) begin
      int n;
      n = int'($urandom_range(1, 12));
      fill_payload(n);
      do_load(8'($urandom), 8'($urandom), 8'(n), 1'($urandom), CK_EN ? 1'($urandom) : 1'b0);
      for (int i = 0; i < 12; i++) read_chk(8'($urandom_range(0, 15)), 1'($urandom));
    end

    if (CK_EN) begin
      payload.delete();
      payload.push_back(8'h01);
      payload.push_back(8'h02);
      do_load(8'h30, 8'h40, 8'd2, 1'b0, 1'b0);
      check("ck_good_run", 32'(run), 32'd1);
      do_load(8'h30, 8'h40, 8'd2, 1'b0, 1'b1);
      check("ck_bad_err", 32'(err), 32'd1);
      check("ck_bad_run", 32'(run), 32'd0);
      read_chk(8'h01, 1'b0);
      pulse_start();
      m_err = 1'b0;
      check("ck_err_cleared", 32'(err), 32'(m_err));
      check("ck_restart_ready", 32'(ld_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
